// File: rtl/cpu_divide_pkg.sv
// Shared types and helpers for the RV32M divide/remainder unit.
package cpu_divide_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;
    localparam logic [XLEN-1:0]  INT_MIN   = 32'h8000_0000;

    // Low two bits of the RV32M funct3 encodings
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIVIDE = 2'b01,
        ST_DONE   = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Unsigned magnitude; |INT_MIN| stays 0x80000000 when viewed unsigned
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/cpu_divide_step.sv
// One radix-2 restoring iteration: shift {R,Q} left, conditionally subtract divisor.
module cpu_divide_step
    import cpu_divide_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic          w_ge;

    // Partial remainder is always below the divisor, so 32 stored bits suffice
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, i_divisor};
    assign o_rem   = w_ge ? XLEN'(w_shift - {1'b0, i_divisor}) : w_shift[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/cpu_divide.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit with valid/ready request and one-cycle result strobe.
// CPU_DIVIDE_FAST_PATH_EN: divide-by-zero and signed overflow complete in one cycle.
module cpu_divide
    import cpu_divide_pkg::*;
(
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e       r_state;
    div_state_e       w_state_next;
    div_op_e          r_op;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_special_res;
    logic [XLEN-1:0]  r_result;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_special;
    logic [CNT_W-1:0] r_count;

    div_op_e          w_op_in;
    logic             w_accept;
    logic             w_in_signed;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special_in;
    logic             w_fast;
    logic             w_last_iter;
    logic [XLEN-1:0]  w_special_val;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quo_next;
    logic [XLEN-1:0]  w_final;

    assign w_op_in      = div_op_e'(i_op);
    assign w_accept     = i_valid && (r_state == ST_IDLE) && !i_flush;
    assign w_in_signed  = op_is_signed(w_op_in);
    assign w_div_zero   = (i_op2 == '0);
    assign w_overflow   = w_in_signed && (i_op1 == INT_MIN) && (i_op2 == '1);
    assign w_special_in = w_div_zero || w_overflow;
    assign w_last_iter  = (r_count == LAST_ITER);

`ifdef CPU_DIVIDE_FAST_PATH_EN
    assign w_fast = w_special_in;
`else
    assign w_fast = 1'b0;
`endif

    // Architecturally defined results for divide-by-zero and INT_MIN / -1
    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = op_is_rem(w_op_in) ? i_op1 : '1;
        end else begin
            w_special_val = op_is_rem(w_op_in) ? '0 : INT_MIN;
        end
    end

    cpu_divide_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    // Sign fix-up of the final iteration's output, or the forced special value
    always_comb begin
        w_final = '0;
        if (r_special) begin
            w_final = r_special_res;
        end else if (op_is_rem(r_op)) begin
            w_final = r_neg_r ? XLEN'(-w_rem_next) : w_rem_next;
        end else begin
            w_final = r_neg_q ? XLEN'(-w_quo_next) : w_quo_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = w_fast ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE: if (w_last_iter) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        if (i_flush) w_state_next = ST_IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    // Operand capture, iteration and result register
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_op          <= OP_DIV;
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_special_res <= '0;
            r_result      <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_special     <= 1'b0;
            r_count       <= '0;
        end else if (w_accept) begin
            r_op          <= w_op_in;
            r_divisor     <= magnitude(i_op2, w_in_signed);
            r_quo         <= magnitude(i_op1, w_in_signed);
            r_rem         <= '0;
            r_neg_q       <= w_in_signed && (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
            r_neg_r       <= w_in_signed && i_op1[XLEN-1];
            r_special     <= w_special_in;
            r_special_res <= w_special_val;
            r_count       <= '0;
            if (w_fast) r_result <= w_special_val;
        end else if ((r_state == ST_DIVIDE) && !i_flush) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count + CNT_W'(1);
            if (w_last_iter) r_result <= w_final;
        end
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_valid  = (r_state == ST_DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_cpu_divide.sv
// Self-checking bench for cpu_divide: directed cases plus random ops against an arithmetic model.
module tb_cpu_divide;
    import cpu_divide_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_flush;
    logic [1:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    cpu_divide dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_op1     (i_op1),
        .i_op2     (i_op2),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .o_result  (o_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics via plain signed/unsigned arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return 32'($signed(x) / $signed(y));
            OP_DIVU: return x / y;
            OP_REM:  return 32'($signed(x) % $signed(y));
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic special;
        special = (y == 32'd0) ||
                  (((op == OP_DIV) || (op == OP_REM)) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef CPU_DIVIDE_FAST_PATH_EN
        return special ? 1 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    // Issue one request, measure latency from the accept cycle, check result and return to idle
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        int          lat;
        int          exp_lat;
        logic [31:0] exp;
        exp     = ref_result(op, x, y);
        exp_lat = ref_latency(op, x, y);
        lat     = 0;
        @(negedge clk);
        check({tag, " ready_before"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_op = op; i_op1 = x; i_op2 = y;
        @(negedge clk);
        i_valid = 1'b0; i_op = 2'($urandom); i_op1 = $urandom; i_op2 = $urandom;
        for (int c = 1; c <= 40; c++) begin
            if (o_valid) begin
                lat = c;
                break;
            end
            if (c == 1) check({tag, " ready_busy"}, 32'(o_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, o_result, exp);
        last_res = exp;
        @(negedge clk);
        check({tag, " valid_one_cycle"}, 32'(o_valid), 32'd0);
        check({tag, " ready_after"}, 32'(o_ready), 32'd1);
        check({tag, " result_held"}, o_result, exp);
    endtask

    initial begin
        int          seen;
        int          lat2;
        int          pick;
        logic [1:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;

        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
        i_op = OP_DIV; i_op1 = '0; i_op2 = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(o_ready), 32'd1);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset result", o_result, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_by0", OP_DIV, 32'h1234_5678, 32'd0);
        run_op("remu_by0", OP_REMU, 32'h1234_5678, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_intmin_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_intmin_2", OP_DIV, 32'h8000_0000, 32'd2);

        // Flush in cycle 10 of a DIVU: abandoned, no strobe, result unchanged
        @(negedge clk);
        i_valid = 1'b1; i_op = OP_DIVU; i_op1 = 32'd1000; i_op2 = 32'd3;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("flush ready_c11", 32'(o_ready), 32'd1);
        check("flush result_kept", o_result, last_res);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        check("flush no_valid", 32'(seen), 32'd0);

        // Flush coincident with a request in IDLE wins
        i_valid = 1'b1; i_flush = 1'b1; i_op = OP_DIVU; i_op1 = 32'd10; i_op2 = 32'd2;
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_idle ready", 32'(o_ready), 32'd1);

        // Reset mid-divide
        i_valid = 1'b1; i_op = OP_DIVU; i_op1 = 32'd50; i_op2 = 32'd5;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset ready", 32'(o_ready), 32'd1);
        check("midreset valid", 32'(o_valid), 32'd0);
        check("midreset result", o_result, 32'd0);
        rst_n = 1'b1;

        // DIVU 9/3 with i_valid held through DONE: second accept lands in cycle 34
        i_valid = 1'b1; i_op = OP_DIVU; i_op1 = 32'd9; i_op2 = 32'd3;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 32) check("held valid_c32", 32'(o_valid), 32'd0);
            if (c == 33) begin
                check("held valid_c33", 32'(o_valid), 32'd1);
                check("held result_c33", o_result, 32'd3);
                check("held ready_c33", 32'(o_ready), 32'd0);
            end
            if (c == 34) begin
                check("held ready_c34", 32'(o_ready), 32'd1);
                check("held valid_c34", 32'(o_valid), 32'd0);
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        check("held second_accept", 32'(o_ready), 32'd0);
        lat2 = 0;
        for (int c = 35; c <= 80; c++) begin
            if (o_valid) begin
                lat2 = c;
                break;
            end
            @(negedge clk);
        end
        check("held second_valid_cycle", 32'(lat2), 32'd67);
        check("held second_result", o_result, 32'd3);
        last_res = 32'd3;
        @(negedge clk);

        // Random ops biased toward the corner cases
        for (int n = 0; n < 24; n++) begin
            rop  = 2'($urandom);
            rx   = $urandom;
            ry   = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0) ry = 32'd0;
            if (pick == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            if (pick == 2) ry = 32'($urandom_range(1, 15));
            if (pick == 3) ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            run_op($sformatf("rand%0d op%0d %h/%h", n, rop, rx, ry), rop, rx, ry);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
